// File: rtl/arm_pkg.sv
// Shared ARM definitions: opcodes, condition codes, flag bit positions and
// the opcode-to-flag-update classification used by the writeback stage.
package arm_pkg;

    // Data-processing opcodes (5-bit ALU operation field)
    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_EOR = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_RSB = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_ADC = 5'b00101;
    localparam logic [4:0] OP_SBC = 5'b00110;
    localparam logic [4:0] OP_RSC = 5'b00111;
    localparam logic [4:0] OP_TST = 5'b01000;
    localparam logic [4:0] OP_TEQ = 5'b01001;
    localparam logic [4:0] OP_CMP = 5'b01010;
    localparam logic [4:0] OP_CMN = 5'b01011;
    localparam logic [4:0] OP_ORR = 5'b01100;
    localparam logic [4:0] OP_MOV = 5'b01101;
    localparam logic [4:0] OP_BIC = 5'b01110;
    localparam logic [4:0] OP_MVN = 5'b01111;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Flag bit positions within a 4-bit NZCV vector
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    // Which flags an opcode is allowed to write
    typedef enum logic [1:0] {
        FUPD_NONE = 2'd0,
        FUPD_NZ   = 2'd1,
        FUPD_NZCV = 2'd2
    } flag_upd_e;

    // Logical ops write N,Z only; add/sub family writes all four; others none
    function automatic flag_upd_e flag_class(input logic [4:0] op);
        flag_upd_e cls;
        case (op)
            OP_AND, OP_EOR, OP_TST, OP_TEQ,
            OP_ORR, OP_MOV, OP_BIC, OP_MVN: cls = FUPD_NZ;
            OP_SUB, OP_RSB, OP_ADD,
            OP_CMP, OP_CMN:                 cls = FUPD_NZCV;
            default:                        cls = FUPD_NONE;
        endcase
        return cls;
    endfunction

    // Test/compare ops exist only to set flags, so they ignore the S bit
    function automatic logic is_compare(input logic [4:0] op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluator: decides whether an instruction executes given
// its condition field and the current NZCV flags. Purely combinational.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic z, c, n, v;
    logic base;

    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign n = flags_i[FLAG_N];
    assign v = flags_i[FLAG_V];

    // Conditions come in complementary pairs: bits [3:1] pick the test,
    // bit 0 inverts it. AL/NV fall out of the same rule (1 and !1).
    always_comb begin
        base = 1'b0;
        case (cond_i[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            3'd7: base = 1'b1;
            default: base = 1'b0;
        endcase
        pass_o = base ^ cond_i[0];
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage after the ALU: evaluates the condition field
// against the CPSR flags it owns, updates flags, counts executed/skipped
// instructions and presents one registered write beat per accepted input.
module alu_writeback_stage
    import arm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       alu_result,
    input  logic [3:0]        alu_flags,
    input  logic              alu_wb,
    input  logic [4:0]        operation,
    input  logic [3:0]        cond,
    input  logic              set_flags,
    input  logic [3:0]        dest_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic [3:0]        cpsr_flags,
    output logic [CNT_W-1:0]  exec_count,
    output logic [CNT_W-1:0]  skip_count
);

    logic              out_valid_q, out_valid_d;
    logic              wb_en_q,     wb_en_d;
    logic [3:0]        wb_addr_q,   wb_addr_d;
    logic [31:0]       wb_data_q,   wb_data_d;
    logic [3:0]        cpsr_q,      cpsr_d;
    logic [CNT_W-1:0]  exec_q,      exec_d;
    logic [CNT_W-1:0]  skip_q,      skip_d;

    logic accept;
    logic pass;
    logic upd_en;

    cond_check u_cond_check (
        .cond_i  (cond),
        .flags_i (cpsr_q),
        .pass_o  (pass)
    );

    // Output register frees up when empty or being drained this cycle
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign upd_en   = set_flags || is_compare(operation);

    // Next-state: load a beat on accept, drop it on drain, else hold all
    always_comb begin
        out_valid_d = out_valid_q;
        wb_en_d     = wb_en_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        cpsr_d      = cpsr_q;
        exec_d      = exec_q;
        skip_d      = skip_q;

        if (accept) begin
            out_valid_d = 1'b1;
            wb_en_d     = pass && alu_wb;
            wb_addr_d   = dest_reg;
            wb_data_d   = alu_result;
            if (pass) begin
                exec_d = exec_q + CNT_W'(1);
                if (upd_en) begin
                    case (flag_class(operation))
                        FUPD_NZ: begin
                            cpsr_d[FLAG_N] = alu_flags[FLAG_N];
                            cpsr_d[FLAG_Z] = alu_flags[FLAG_Z];
                        end
                        FUPD_NZCV: cpsr_d = alu_flags;
                        default:   cpsr_d = cpsr_q;
                    endcase
                end
            end else begin
                skip_d = skip_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; asynchronous reset clears any pending beat at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            cpsr_q      <= '0;
            exec_q      <= '0;
            skip_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            cpsr_q      <= cpsr_d;
            exec_q      <= exec_d;
            skip_q      <= skip_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign wb_en      = wb_en_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign cpsr_flags = cpsr_q;
    assign exec_count = exec_q;
    assign skip_count = skip_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed scenarios plus a randomized run,
// all checked against a behavioural model of the stage kept here.
module tb_alu_writeback_stage;

    localparam int CW = 4;  // narrow counters so the random run wraps them

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   alu_result;
    logic [3:0]    alu_flags;
    logic          alu_wb;
    logic [4:0]    operation;
    logic [3:0]    cond;
    logic          set_flags;
    logic [3:0]    dest_reg;
    logic          out_valid;
    logic          out_ready;
    logic          wb_en;
    logic [3:0]    wb_addr;
    logic [31:0]   wb_data;
    logic [3:0]    cpsr_flags;
    logic [CW-1:0] exec_count;
    logic [CW-1:0] skip_count;

    int total = 0;
    int bad   = 0;

    // Model state
    bit          m_ov;
    bit          m_en;
    bit [3:0]    m_addr;
    bit [31:0]   m_data;
    bit [3:0]    m_flags;
    bit [CW-1:0] m_exec;
    bit [CW-1:0] m_skip;
    bit          exp_in_ready;
    logic        obs_in_ready;

    alu_writeback_stage #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .alu_wb     (alu_wb),
        .operation  (operation),
        .cond       (cond),
        .set_flags  (set_flags),
        .dest_reg   (dest_reg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .cpsr_flags (cpsr_flags),
        .exec_count (exec_count),
        .skip_count (skip_count)
    );

    always #5 clk = ~clk;

    // Condition truth table written directly from the named flags
    function automatic bit m_pass(input bit [3:0] c, input bit [3:0] f);
        bit z, cy, n, v;
        z = f[0]; cy = f[1]; n = f[2]; v = f[3];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic reset_model();
        m_ov = 0; m_en = 0; m_addr = 0; m_data = 0;
        m_flags = 0; m_exec = 0; m_skip = 0;
    endtask

    // Present one input cycle starting at a negedge, advance the model at
    // the rising edge, return at the following negedge.
    task automatic drive(input bit v, input bit [31:0] res, input bit [3:0] fl,
                         input bit wb, input bit [4:0] op, input bit [3:0] cnd,
                         input bit s, input bit [3:0] dst, input bit ordy);
        bit p;
        in_valid = v; alu_result = res; alu_flags = fl; alu_wb = wb;
        operation = op; cond = cnd; set_flags = s; dest_reg = dst;
        out_ready = ordy;
        #1;
        obs_in_ready = in_ready;
        exp_in_ready = !m_ov || ordy;
        @(posedge clk);
        if (v && exp_in_ready) begin
            p = m_pass(cnd, m_flags);
            m_ov = 1; m_en = p && wb; m_addr = dst; m_data = res;
            if (p) begin
                m_exec = m_exec + 1'b1;
                if (s || (op >= 5'd8 && op <= 5'd11)) begin
                    if (op inside {5'd0, 5'd1, 5'd8, 5'd9, 5'd12, 5'd13, 5'd14, 5'd15}) begin
                        m_flags[2] = fl[2];
                        m_flags[0] = fl[0];
                    end else if (op inside {5'd2, 5'd3, 5'd4, 5'd10, 5'd11}) begin
                        m_flags = fl;
                    end
                end
            end else begin
                m_skip = m_skip + 1'b1;
            end
        end else if (ordy) begin
            m_ov = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        drive(0, 32'h0, 4'h0, 0, 5'd0, 4'd14, 0, 4'd0, ordy);
    endtask

    task automatic test_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (cpsr_flags !== 4'b0000) begin bad++; $display("FAIL reset_cpsr got=%b want=0000", cpsr_flags); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (exec_count !== '0 || skip_count !== '0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", exec_count, skip_count); end
        total++; if ({wb_en, wb_addr, wb_data} !== 37'h0) begin bad++; $display("FAIL reset_wb got=%b/%h/%h want=0/0/0", wb_en, wb_addr, wb_data); end
    endtask

    task automatic test_forwarding();
        // CMP with Z result, always executes
        drive(1, 32'h0, 4'b0001, 0, 5'd10, 4'd14, 0, 4'd0, 1);
        total++; if (cpsr_flags !== 4'b0001) begin bad++; $display("FAIL fwd_cmp_flags got=%b want=0001", cpsr_flags); end
        total++; if (out_valid !== 1'b1 || wb_en !== 1'b0) begin bad++; $display("FAIL fwd_cmp_beat got=%b/%b want=1/0", out_valid, wb_en); end
        // ADD EQ right behind it sees the new Z
        drive(1, 32'd10, 4'b0000, 1, 5'd4, 4'd0, 0, 4'd3, 1);
        total++; if (wb_en !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 32'd10) begin bad++; $display("FAIL fwd_add_beat got=%b/%0d/%0d want=1/3/10", wb_en, wb_addr, wb_data); end
        total++; if (exec_count !== CW'(2)) begin bad++; $display("FAIL fwd_exec got=%0d want=2", exec_count); end
        total++; if (cpsr_flags !== 4'b0001) begin bad++; $display("FAIL fwd_add_flags got=%b want=0001", cpsr_flags); end
    endtask

    task automatic test_cond_fail();
        drive(1, 32'h55, 4'b0100, 1, 5'd2, 4'd1, 1, 4'd5, 1);
        total++; if (out_valid !== 1'b1 || wb_en !== 1'b0 || wb_addr !== 4'd5 || wb_data !== 32'h55) begin bad++; $display("FAIL fail_beat got=%b/%b/%0d/%h want=1/0/5/55", out_valid, wb_en, wb_addr, wb_data); end
        total++; if (cpsr_flags !== 4'b0001) begin bad++; $display("FAIL fail_flags got=%b want=0001", cpsr_flags); end
        total++; if (skip_count !== CW'(1) || exec_count !== CW'(2)) begin bad++; $display("FAIL fail_counts got=%0d/%0d want=2/1", exec_count, skip_count); end
    endtask

    task automatic test_logical_preserve();
        drive(1, 32'h0, 4'b1010, 0, 5'd10, 4'd14, 0, 4'd0, 1);
        total++; if (cpsr_flags !== 4'b1010) begin bad++; $display("FAIL lp_setup got=%b want=1010", cpsr_flags); end
        drive(1, 32'h1, 4'b0101, 1, 5'd13, 4'd14, 1, 4'd7, 1);
        total++; if (cpsr_flags !== 4'b1111) begin bad++; $display("FAIL lp_mov_flags got=%b want=1111", cpsr_flags); end
        // ADC is outside both update classes: flags must not move
        drive(1, 32'h2, 4'b0000, 1, 5'd5, 4'd14, 1, 4'd7, 1);
        total++; if (cpsr_flags !== 4'b1111) begin bad++; $display("FAIL lp_adc_flags got=%b want=1111", cpsr_flags); end
    endtask

    task automatic test_backpressure();
        bit [CW-1:0] e0;
        e0 = m_exec;
        drive(1, 32'hA1, 4'h0, 1, 5'd4, 4'd14, 0, 4'd1, 1);
        total++; if (wb_data !== 32'hA1 || exec_count !== CW'(e0 + 1)) begin bad++; $display("FAIL bp_first got=%h/%0d want=a1/%0d", wb_data, exec_count, CW'(e0 + 1)); end
        for (int k = 0; k < 2; k++) begin
            drive(1, 32'hB2, 4'h0, 1, 5'd4, 4'd14, 0, 4'd2, 0);
            total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", obs_in_ready); end
            total++; if (out_valid !== 1'b1 || wb_data !== 32'hA1 || wb_addr !== 4'd1) begin bad++; $display("FAIL bp_hold got=%b/%h/%0d want=1/a1/1", out_valid, wb_data, wb_addr); end
            total++; if (exec_count !== CW'(e0 + 1)) begin bad++; $display("FAIL bp_exec_frozen got=%0d want=%0d", exec_count, CW'(e0 + 1)); end
        end
        drive(1, 32'hB2, 4'h0, 1, 5'd4, 4'd14, 0, 4'd2, 1);
        total++; if (obs_in_ready !== 1'b1 || wb_data !== 32'hB2 || wb_addr !== 4'd2) begin bad++; $display("FAIL bp_second got=%b/%h/%0d want=1/b2/2", obs_in_ready, wb_data, wb_addr); end
        drive(1, 32'hC3, 4'h0, 1, 5'd4, 4'd14, 0, 4'd3, 1);
        total++; if (out_valid !== 1'b1 || wb_data !== 32'hC3 || exec_count !== CW'(e0 + 3)) begin bad++; $display("FAIL bp_third got=%b/%h/%0d want=1/c3/%0d", out_valid, wb_data, exec_count, CW'(e0 + 3)); end
        idle(1);
        total++; if (out_valid !== 1'b0 || exec_count !== CW'(e0 + 3)) begin bad++; $display("FAIL bp_drain got=%b/%0d want=0/%0d", out_valid, exec_count, CW'(e0 + 3)); end
    endtask

    task automatic test_async_reset();
        drive(1, 32'hD4, 4'b1111, 1, 5'd2, 4'd14, 1, 4'd9, 1);
        drive(1, 32'hE5, 4'h0, 1, 5'd4, 4'd14, 0, 4'd8, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_stall got=%b want=1", out_valid); end
        #2 reset = 1'b0;
        #1;
        reset_model();
        total++; if (out_valid !== 1'b0 || wb_data !== 32'h0 || wb_en !== 1'b0) begin bad++; $display("FAIL ar_out got=%b/%h/%b want=0/0/0", out_valid, wb_data, wb_en); end
        total++; if (cpsr_flags !== 4'b0 || exec_count !== '0 || skip_count !== '0) begin bad++; $display("FAIL ar_state got=%b/%0d/%0d want=0000/0/0", cpsr_flags, exec_count, skip_count); end
        in_valid = 0;
        @(negedge clk);
        reset = 1'b1;
        drive(1, 32'h77, 4'h0, 1, 5'd13, 4'd14, 0, 4'd4, 1);
        total++; if (out_valid !== 1'b1 || wb_en !== 1'b1 || wb_data !== 32'h77 || exec_count !== CW'(1)) begin bad++; $display("FAIL ar_after got=%b/%b/%h/%0d want=1/1/77/1", out_valid, wb_en, wb_data, exec_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom), 1'($urandom),
                  5'($urandom_range(0, 31)), 4'($urandom), 1'($urandom),
                  4'($urandom), $urandom_range(0, 9) < 7);
            total++; if (obs_in_ready !== exp_in_ready) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", i, obs_in_ready, exp_in_ready); end
            total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", i, out_valid, m_ov); end
            if (m_ov) begin
                total++; if (wb_en !== m_en || wb_addr !== m_addr || wb_data !== m_data) begin bad++; $display("FAIL rnd_beat cyc=%0d got=%b/%h/%h want=%b/%h/%h", i, wb_en, wb_addr, wb_data, m_en, m_addr, m_data); end
            end
            total++; if (cpsr_flags !== m_flags) begin bad++; $display("FAIL rnd_flags cyc=%0d got=%b want=%b", i, cpsr_flags, m_flags); end
            total++; if (exec_count !== m_exec || skip_count !== m_skip) begin bad++; $display("FAIL rnd_counts cyc=%0d got=%0d/%0d want=%0d/%0d", i, exec_count, skip_count, m_exec, m_skip); end
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 0; alu_result = 0; alu_flags = 0; alu_wb = 0;
        operation = 0; cond = 0; set_flags = 0; dest_reg = 0; out_ready = 1;
        reset_model();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_cond_fail();
        test_logical_preserve();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Execute/writeback pipeline stage directly downstream of the ALU. It accepts one ALU result per handshake and evaluates the instruction's ARM condition field against the architectural flag register (CPSR NZCV). It updates those flags when required and presents a registered register-file write beat to the register file. It owns the only copy of the flags, so condition evaluation for every instruction sees the flags of all previously accepted instructions.

## Interface
Parameters:
- CNT_W, 16: width of the executed/skipped instruction counters.

Ports:
- clk  input  1  stage clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- alu_result  input  32  ALU result.
- alu_flags  input  4  ALU flags, bit0 Z, bit1 C, bit2 N, bit3 V.
- alu_wb  input  1  ALU writeback-request bit (0 for TST/TEQ/CMP/CMN/undefined).
- operation  input  5  ALU opcode of this beat.
- cond  input  4  ARM condition field.
- set_flags  input  1  instruction S bit.
- dest_reg  input  4  destination register index.
- out_valid  output  1  write beat valid.
- out_ready  input  1  register file accepts the beat.
- wb_en  output  1  register file write enable for this beat.
- wb_addr  output  4  write address.
- wb_data  output  32  write data.
- cpsr_flags  output  4  current flags, same bit order as alu_flags.
- exec_count  output  CNT_W  beats whose condition passed.
- skip_count  output  CNT_W  beats whose condition failed.

## Operation
- Accept: in_valid && in_ready.
- pass is computed combinationally from cond and current cpsr_flags:
  - EQ 0000: Z. NE 0001: !Z. CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N. VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !C|Z. GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: Z|(N!=V). AL 1110: 1. NV 1111: 0.
- On accept with pass=1, the flag update is enabled when set_flags=1 or operation is 01000..01011 (compare ops always set flags):
  - Logical ops 00000, 00001, 01000, 01001, 01100, 01101, 01110, 01111: update N,Z only; C,V retained.
  - Arithmetic ops 00010, 00011, 00100, 01010, 01011: update all four.
  - Any other opcode: no flag update.
- On accept with pass=0: flags unchanged; skip_count increments.
- On accept with pass=1: exec_count increments.
- Counters wrap modulo 2^CNT_W.
- Every accepted beat produces exactly one output beat, in order:
  - wb_en = pass && alu_wb.
  - wb_addr = dest_reg; wb_data = alu_result, captured even when wb_en=0.

## Timing
- Reset values:
  - out_valid=0, wb_en=0, wb_addr=0, wb_data=0.
  - cpsr_flags=0, exec_count=0, skip_count=0.
  - in_ready=1 (combinational, see below).
- Single output register, latency 1: the beat accepted at edge t is visible on the out_* ports after edge t.
- in_ready = !out_valid || out_ready (combinational). Full throughput of one beat per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0. out_* held stable, in_ready=0, flags and counters frozen.
- Flags update on the accept edge, so back-to-back beats see forwarded flags:
  - A CMP accepted at edge t sets flags at t.
  - A conditional beat presented in the following cycle evaluates against the new flags.
- Simultaneous drain and accept: out_ready=1 and in_valid=1 with out_valid=1 loads the new beat, and out_valid stays 1.
- Drain only: out_ready=1 and in_valid=0 clears out_valid.
- Reset asserted mid-stall: pending beat discarded, all state returns to reset values immediately (asynchronous).

## Structure
- Shared package arm_pkg:
  - Opcode constants (AND..MVN, 5-bit).
  - Condition-code constants (EQ..NV).
  - Flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3.
  - The ALU uses the same package.
- One combinational sub-module, cond_check (cond, flags -> pass); it is reused later by the branch unit.
- Top holds the output register, CPSR register, counters and handshake logic.

## Test plan
- Reset, then no traffic: out_valid=0, cpsr_flags=0000, in_ready=1, both counters 0.
- Flag update and forwarding: CMP (01010), alu_flags=0001 (Z), cond=AL, accepted at t. Next cycle an ADD with cond=EQ, alu_wb=1, dest_reg=3, alu_result=10 is accepted. Required:
  - cpsr_flags=0001 after t.
  - Second output beat wb_en=1, wb_addr=3, wb_data=10.
  - exec_count=2.
- Condition fail: with Z=1, SUB with cond=NE, set_flags=1, alu_flags=0100. Required: output beat with wb_en=0, cpsr_flags unchanged 0001, skip_count=1.
- Logical flag preservation: cpsr_flags=1010 (V,C). MOV with S=1, alu_flags=0101. Required: cpsr_flags=1111 (N,Z from ALU; C,V kept).
- Backpressure: 3 back-to-back AL beats with out_ready held 0 for 2 cycles. Required:
  - First beat held stable; in_ready=0 during the stall.
  - All 3 beats emerge in order with no loss or duplication.
  - exec_count advances only on accepts.
- Async reset mid-stall: reset asserted with out_valid=1. Required: out_valid=0, counters 0, cpsr_flags=0000 without waiting for clk. Beats after release proceed normally.
